// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the control sequencer: FSM states, opcodes, IR fields.
// MUL_DIV_EN: when defined, mul/div opcodes decode as legal multi-cycle instructions.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    StIdle, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StHalt
  } state_e;

  typedef enum logic [2:0] {
    ClsAlu3, ClsUnary, ClsMulDiv, ClsNop, ClsHalt, ClsIllegal
  } op_class_e;

  typedef struct packed {
    logic pc_out;
    logic mar_in;
    logic inc_pc;
    logic read;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic y_in;
    logic zlow_in;
    logic zhigh_in;
    logic zlow_out;
    logic zhigh_out;
    logic hi_in;
    logic lo_in;
  } strobes_t;

  localparam logic [4:0] OpAluMax = 5'b01100;
  localparam logic [4:0] OpNeg    = 5'b01101;
  localparam logic [4:0] OpNot    = 5'b01110;
  localparam logic [4:0] OpMul    = 5'b01111;
  localparam logic [4:0] OpDiv    = 5'b10000;
  localparam logic [4:0] OpNop    = 5'b11011;
  localparam logic [4:0] OpHalt   = 5'b11100;

  localparam int unsigned OpMsb = 31;
  localparam int unsigned OpLsb = 27;
  localparam int unsigned RaMsb = 26;
  localparam int unsigned RaLsb = 23;
  localparam int unsigned RbMsb = 22;
  localparam int unsigned RbLsb = 19;
  localparam int unsigned RcMsb = 18;
  localparam int unsigned RcLsb = 15;

  function automatic op_class_e op_class(input logic [4:0] op);
    op_class_e cls;
    if (op <= OpAluMax) begin
      cls = ClsAlu3;
    end else begin
      case (op)
        OpNeg, OpNot: cls = ClsUnary;
`ifdef MUL_DIV_EN
        OpMul, OpDiv: cls = ClsMulDiv;
`else
        OpMul, OpDiv: cls = ClsIllegal;
`endif
        OpNop:        cls = ClsNop;
        OpHalt:       cls = ClsHalt;
        default:      cls = ClsIllegal;
      endcase
    end
    return cls;
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer <-> datapath bundle: fetch handshake inputs, datapath strobes and status.
interface control_sequencer_if;
  logic        run;
  logic [31:0] ir;
  logic        mem_rdy;
  logic        PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, Yin;
  logic        ZLowIn, ZHighIn, ZLowout, ZHighout, HIin, LOin;
  logic [15:0] reg_out;
  logic [15:0] reg_in;
  logic [4:0]  operation;
  logic        halted;
  logic        illegal_op;
  logic [15:0] instr_count;

  modport master (
    input  run, ir, mem_rdy,
    output PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, Yin,
    output ZLowIn, ZHighIn, ZLowout, ZHighout, HIin, LOin,
    output reg_out, reg_in, operation, halted, illegal_op, instr_count
  );

  modport slave (
    output run, ir, mem_rdy,
    input  PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, Yin,
    input  ZLowIn, ZHighIn, ZLowout, ZHighout, HIin, LOin,
    input  reg_out, reg_in, operation, halted, illegal_op, instr_count
  );
endinterface

// File: rtl/reg_select_decode.sv
// 4-bit register index plus enable to 16-bit one-hot select.
module reg_select_decode (
  input  logic [3:0]  i_idx,
  input  logic        i_en,
  output logic [15:0] o_onehot
);
  always_comb begin
    o_onehot = '0;
    if (i_en) o_onehot[i_idx] = 1'b1;
  end
endmodule

// File: rtl/control_sequencer.sv
// Fetch/execute control FSM driving datapath strobes and register selects.
// MUL_DIV_EN enables the mul/div sequence (T3..T6); otherwise those opcodes trap as illegal.
module control_sequencer
  import cpu_ctrl_pkg::*;
(
  input logic                 clk,
  input logic                 clr,
  control_sequencer_if.master bus
);

  state_e      r_state;
  op_class_e   r_cls;
  logic [4:0]  r_op;
  logic [3:0]  r_ra, r_rb, r_rc;
  logic        r_illegal;
  logic [15:0] r_count;

  logic        w_in_t3;
  op_class_e   w_cls;
  logic [4:0]  w_op;
  logic [3:0]  w_ra, w_rb, w_rc;
  strobes_t    w_strb;
  logic        w_out_en, w_in_en, w_alu;
  logic [3:0]  w_out_idx;
  logic [15:0] w_reg_out, w_reg_in;
  logic        w_unused_ir;

  // IR is only valid from T3 on; later cycles use the copy captured when leaving T3.
  assign w_in_t3 = (r_state == StT3);
  assign w_op    = w_in_t3 ? bus.ir[OpMsb:OpLsb] : r_op;
  assign w_ra    = w_in_t3 ? bus.ir[RaMsb:RaLsb] : r_ra;
  assign w_rb    = w_in_t3 ? bus.ir[RbMsb:RbLsb] : r_rb;
  assign w_rc    = w_in_t3 ? bus.ir[RcMsb:RcLsb] : r_rc;
  assign w_cls   = w_in_t3 ? op_class(bus.ir[OpMsb:OpLsb]) : r_cls;
  assign w_unused_ir = ^bus.ir[RcLsb-1:0];

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state   <= StIdle;
      r_cls     <= ClsNop;
      r_op      <= '0;
      r_ra      <= '0;
      r_rb      <= '0;
      r_rc      <= '0;
      r_illegal <= 1'b0;
      r_count   <= '0;
    end else begin
      case (r_state)
        StIdle: if (bus.run) r_state <= StT0;
        StT0:   r_state <= StT1;
        StT1:   if (bus.mem_rdy) r_state <= StT2;
        StT2:   r_state <= StT3;
        StT3: begin
          r_op  <= w_op;
          r_ra  <= w_ra;
          r_rb  <= w_rb;
          r_rc  <= w_rc;
          r_cls <= w_cls;
          case (w_cls)
            ClsAlu3, ClsUnary, ClsMulDiv: r_state <= StT4;
            ClsNop: begin
              r_count <= r_count + 16'd1;
              r_state <= StT0;
            end
            ClsHalt: r_state <= StHalt;
            default: begin
              r_illegal <= 1'b1;
              r_state   <= StHalt;
            end
          endcase
        end
        StT4: begin
          if (r_cls == ClsUnary) begin
            r_count <= r_count + 16'd1;
            r_state <= StT0;
          end else begin
            r_state <= StT5;
          end
        end
        StT5: begin
          if (r_cls == ClsMulDiv) begin
            r_state <= StT6;
          end else begin
            r_count <= r_count + 16'd1;
            r_state <= StT0;
          end
        end
        StT6: begin
          r_count <= r_count + 16'd1;
          r_state <= StT0;
        end
        StHalt: begin
          if (bus.run) begin
            r_illegal <= 1'b0;
            r_state   <= StT0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_comb begin
    w_strb    = '0;
    w_out_en  = 1'b0;
    w_out_idx = w_rb;
    w_in_en   = 1'b0;
    w_alu     = 1'b0;
    case (r_state)
      StT0: begin
        w_strb.pc_out = 1'b1;
        w_strb.mar_in = 1'b1;
        w_strb.inc_pc = 1'b1;
      end
      StT1: begin
        w_strb.read   = 1'b1;
        w_strb.mdr_in = bus.mem_rdy;
      end
      StT2: begin
        w_strb.mdr_out = 1'b1;
        w_strb.ir_in   = 1'b1;
      end
      StT3: begin
        case (w_cls)
          ClsAlu3: begin
            w_out_en    = 1'b1;
            w_strb.y_in = 1'b1;
          end
          ClsMulDiv: begin
            w_out_en    = 1'b1;
            w_out_idx   = w_ra;
            w_strb.y_in = 1'b1;
          end
          ClsUnary: begin
            w_out_en = 1'b1;
            w_alu    = 1'b1;
          end
          default: ;
        endcase
      end
      StT4: begin
        case (w_cls)
          ClsAlu3: begin
            w_out_en  = 1'b1;
            w_out_idx = w_rc;
            w_alu     = 1'b1;
          end
          ClsMulDiv: begin
            w_out_en = 1'b1;
            w_alu    = 1'b1;
          end
          ClsUnary: begin
            w_strb.zlow_out = 1'b1;
            w_in_en         = 1'b1;
          end
          default: ;
        endcase
      end
      StT5: begin
        if (w_cls == ClsMulDiv) begin
          w_strb.zlow_out = 1'b1;
          w_strb.lo_in    = 1'b1;
        end else if (w_cls == ClsAlu3) begin
          w_strb.zlow_out = 1'b1;
          w_in_en         = 1'b1;
        end
      end
      StT6: begin
        w_strb.zhigh_out = 1'b1;
        w_strb.hi_in     = 1'b1;
      end
      default: ;
    endcase
    w_strb.zlow_in  = w_alu;
    w_strb.zhigh_in = w_alu;
  end

  reg_select_decode u_out_sel (
    .i_idx    (w_out_idx),
    .i_en     (w_out_en),
    .o_onehot (w_reg_out)
  );

  // R0 is hard-wired: its load select is suppressed but the instruction still retires.
  reg_select_decode u_in_sel (
    .i_idx    (w_ra),
    .i_en     (w_in_en && (w_ra != 4'd0)),
    .o_onehot (w_reg_in)
  );

  assign bus.PCout       = w_strb.pc_out;
  assign bus.MARin       = w_strb.mar_in;
  assign bus.IncPC       = w_strb.inc_pc;
  assign bus.Read        = w_strb.read;
  assign bus.MDRin       = w_strb.mdr_in;
  assign bus.MDRout      = w_strb.mdr_out;
  assign bus.IRin        = w_strb.ir_in;
  assign bus.Yin         = w_strb.y_in;
  assign bus.ZLowIn      = w_strb.zlow_in;
  assign bus.ZHighIn     = w_strb.zhigh_in;
  assign bus.ZLowout     = w_strb.zlow_out;
  assign bus.ZHighout    = w_strb.zhigh_out;
  assign bus.HIin        = w_strb.hi_in;
  assign bus.LOin        = w_strb.lo_in;
  assign bus.reg_out     = w_reg_out;
  assign bus.reg_in      = w_reg_in;
  assign bus.operation   = w_alu ? w_op : 5'd0;
  assign bus.halted      = (r_state == StHalt);
  assign bus.illegal_op  = r_illegal;
  assign bus.instr_count = r_count;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: vector table for one add, hand sequences for the rest.
module tb_control_sequencer;

  localparam logic [31:0] IrAdd  = 32'h0091_8000;
  localparam logic [31:0] IrNot  = 32'h7010_0000;
  localparam logic [31:0] IrMul  = 32'h7910_0000;
  localparam logic [31:0] IrNop  = 32'hD800_0000;
  localparam logic [31:0] IrHalt = 32'hE000_0000;

  // Strobe order: PCout MARin IncPC Read MDRin MDRout IRin Yin ZLowIn ZHighIn ZLowout ZHighout HIin LOin
  localparam logic [13:0] SFetch = 14'h3800;
  localparam logic [13:0] SRead  = 14'h0400;
  localparam logic [13:0] SMdrIn = 14'h0200;
  localparam logic [13:0] SIrLd  = 14'h0180;
  localparam logic [13:0] SY     = 14'h0040;
  localparam logic [13:0] SZin   = 14'h0030;
  localparam logic [13:0] SZlo   = 14'h0008;
  localparam logic [13:0] SZhi   = 14'h0004;
  localparam logic [13:0] SHi    = 14'h0002;
  localparam logic [13:0] SLo    = 14'h0001;

  typedef struct {
    logic        run;
    logic        mem_rdy;
    logic [31:0] ir;
    logic [13:0] strb;
    logic [15:0] rout;
    logic [15:0] rin;
    logic [4:0]  op;
    logic [15:0] cnt;
  } vec_t;

  logic clk = 1'b0;
  logic clr = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [15:0] exp_cnt;
  logic [13:0] strobes;
  vec_t vecs [11];

  control_sequencer_if bus ();

  control_sequencer dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign strobes = {bus.PCout, bus.MARin, bus.IncPC, bus.Read, bus.MDRin, bus.MDRout, bus.IRin,
                    bus.Yin, bus.ZLowIn, bus.ZHighIn, bus.ZLowout, bus.ZHighout, bus.HIin,
                    bus.LOin};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string name, input logic [13:0] strb, input logic [15:0] rout,
                         input logic [15:0] rin, input logic [4:0] op, input logic hlt,
                         input logic ill, input logic [15:0] cnt);
    chk({name, ".strb"}, 32'(strobes), 32'(strb));
    chk({name, ".reg_out"}, 32'(bus.reg_out), 32'(rout));
    chk({name, ".reg_in"}, 32'(bus.reg_in), 32'(rin));
    chk({name, ".operation"}, 32'(bus.operation), 32'(op));
    chk({name, ".halted"}, 32'(bus.halted), 32'(hlt));
    chk({name, ".illegal_op"}, 32'(bus.illegal_op), 32'(ill));
    chk({name, ".instr_count"}, 32'(bus.instr_count), 32'(cnt));
  endtask

  // Each call is one cycle: inputs change at the falling edge, outputs checked 1 ns later.
  task automatic drive(input logic r, input logic m, input logic [31:0] i);
    @(negedge clk);
    bus.run     = r;
    bus.mem_rdy = m;
    bus.ir      = i;
    #1;
  endtask

  initial begin
    bus.run     = 1'b0;
    bus.mem_rdy = 1'b0;
    bus.ir      = '0;

    vecs[0]  = '{1'b1, 1'b0, IrAdd, 14'h0,          16'h0,    16'h0,    5'd0, 16'd0};
    vecs[1]  = '{1'b0, 1'b0, IrAdd, SFetch,         16'h0,    16'h0,    5'd0, 16'd0};
    vecs[2]  = '{1'b0, 1'b0, IrAdd, SRead,          16'h0,    16'h0,    5'd0, 16'd0};
    vecs[3]  = '{1'b0, 1'b0, IrAdd, SRead,          16'h0,    16'h0,    5'd0, 16'd0};
    vecs[4]  = '{1'b0, 1'b0, IrAdd, SRead,          16'h0,    16'h0,    5'd0, 16'd0};
    vecs[5]  = '{1'b0, 1'b1, IrAdd, SRead | SMdrIn, 16'h0,    16'h0,    5'd0, 16'd0};
    vecs[6]  = '{1'b0, 1'b0, IrAdd, SIrLd,          16'h0,    16'h0,    5'd0, 16'd0};
    vecs[7]  = '{1'b0, 1'b0, IrAdd, SY,             16'h0004, 16'h0,    5'd0, 16'd0};
    vecs[8]  = '{1'b0, 1'b0, IrAdd, SZin,           16'h0008, 16'h0,    5'd0, 16'd0};
    vecs[9]  = '{1'b0, 1'b0, IrAdd, SZlo,           16'h0,    16'h0002, 5'd0, 16'd0};
    vecs[10] = '{1'b0, 1'b0, IrAdd, SFetch,         16'h0,    16'h0,    5'd0, 16'd1};

    #1;
    chk_all("reset", 14'h0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0, 16'd0);
    @(negedge clk);
    clr = 1'b1;

    // add R1,R2,R3 with three wait cycles in T1
    for (int k = 0; k < 11; k++) begin
      drive(vecs[k].run, vecs[k].mem_rdy, vecs[k].ir);
      chk_all($sformatf("add[%0d]", k), vecs[k].strb, vecs[k].rout, vecs[k].rin, vecs[k].op,
              1'b0, 1'b0, vecs[k].cnt);
    end
    exp_cnt = 16'd1;

    // not R0,R2: R0 write suppressed, still retires
    drive(1'b0, 1'b1, IrNot);
    chk_all("not.t1", SRead | SMdrIn, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0, exp_cnt);
    drive(1'b0, 1'b0, IrNot);
    chk_all("not.t2", SIrLd, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0, exp_cnt);
    drive(1'b0, 1'b0, IrNot);
    chk_all("not.t3", SZin, 16'h0004, 16'h0, 5'b01110, 1'b0, 1'b0, exp_cnt);
    drive(1'b0, 1'b0, IrNot);
    chk_all("not.t4", SZlo, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0, exp_cnt);
    exp_cnt = exp_cnt + 16'd1;
    drive(1'b0, 1'b0, IrNot);
    chk_all("not.t0", SFetch, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0, exp_cnt);

    // mul R2,R2
    drive(1'b0, 1'b1, IrMul);
    drive(1'b0, 1'b0, IrMul);
    chk_all("mul.t2", SIrLd, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0, exp_cnt);
    drive(1'b0, 1'b0, IrMul);
`ifdef MUL_DIV_EN
    chk_all("mul.t3", SY, 16'h0004, 16'h0, 5'd0, 1'b0, 1'b0, exp_cnt);
    drive(1'b0, 1'b0, IrMul);
    chk_all("mul.t4", SZin, 16'h0004, 16'h0, 5'b01111, 1'b0, 1'b0, exp_cnt);
    drive(1'b0, 1'b0, IrMul);
    chk_all("mul.t5", SZlo | SLo, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0, exp_cnt);
    drive(1'b0, 1'b0, IrMul);
    chk_all("mul.t6", SZhi | SHi, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0, exp_cnt);
    exp_cnt = exp_cnt + 16'd1;
    drive(1'b0, 1'b0, IrMul);
    chk_all("mul.t0", SFetch, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0, exp_cnt);
`else
    chk_all("mul.t3", 14'h0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0, exp_cnt);
    drive(1'b0, 1'b0, IrMul);
    chk_all("mul.halt", 14'h0, 16'h0, 16'h0, 5'd0, 1'b1, 1'b1, exp_cnt);
    drive(1'b1, 1'b0, IrMul);
    chk_all("mul.halt_run", 14'h0, 16'h0, 16'h0, 5'd0, 1'b1, 1'b1, exp_cnt);
    drive(1'b0, 1'b0, IrMul);
    chk_all("mul.rerun", SFetch, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0, exp_cnt);
`endif

    // asynchronous clear in T4 of an add, then run must be seen before fetching
    drive(1'b0, 1'b1, IrAdd);
    drive(1'b0, 1'b0, IrAdd);
    drive(1'b0, 1'b0, IrAdd);
    drive(1'b0, 1'b0, IrAdd);
    chk_all("rst.t4", SZin, 16'h0008, 16'h0, 5'd0, 1'b0, 1'b0, exp_cnt);
    clr = 1'b0;
    #1;
    chk_all("rst.async", 14'h0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0, 16'd0);
    @(negedge clk);
    clr = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b1, IrAdd);
      chk_all($sformatf("rst.idle[%0d]", k), 14'h0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0, 16'd0);
    end
    drive(1'b1, 1'b1, IrNop);
    chk_all("rst.run", 14'h0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0, 16'd0);
    drive(1'b0, 1'b1, IrNop);
    chk_all("rst.t0", SFetch, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0, 16'd0);

    // 65536 nops wrap the retire counter back to zero
    for (int n = 0; n < 65536; n++) begin
      drive(1'b0, 1'b1, IrNop);
      drive(1'b0, 1'b1, IrNop);
      drive(1'b0, 1'b1, IrNop);
      if (n == 0) chk_all("nop.t3", 14'h0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0, 16'd0);
      drive(1'b0, 1'b1, IrNop);
      if (n == 0)     chk("nop.first", 32'(bus.instr_count), 32'h1);
      if (n == 65534) chk("nop.ffff", 32'(bus.instr_count), 32'hFFFF);
    end
    chk_all("nop.wrap", SFetch, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0, 16'd0);

    // halt leaves the counter alone
    drive(1'b0, 1'b1, IrHalt);
    drive(1'b0, 1'b1, IrHalt);
    drive(1'b0, 1'b1, IrHalt);
    chk_all("halt.t3", 14'h0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0, 16'd0);
    drive(1'b0, 1'b1, IrHalt);
    chk_all("halt.st", 14'h0, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 16'd0);
    drive(1'b0, 1'b1, IrHalt);
    chk_all("halt.stay", 14'h0, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
